// File: rtl/regfile_sb.sv
// Dual-write, triple-read register file with a per-register busy scoreboard and a registered busy count.
// Optional same-cycle write-to-read forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWre0,
  input  logic              RegWre1,
  input  logic [ADDR_W-1:0] WriteReg0,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] ReadReg3,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] ReadData3,
  input  logic              IssueWre,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Busy3,
  output logic [ADDR_W:0]   BusyCnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              wrEn0;
  logic              wrEn1;
  logic              issueEn;

  // Register 0 is hardwired: any access to it is dropped at the qualifier.
  assign wrEn0   = RegWre0 && (WriteReg0 != '0);
  assign wrEn1   = RegWre1 && (WriteReg1 != '0);
  assign issueEn = IssueWre && (IssueReg != '0);

  function automatic logic [ADDR_W:0] popCount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Writes clear busy first; a same-cycle issue wins so the bit ends set.
  always_comb begin
    busyNext = busy;
    if (wrEn0) busyNext[WriteReg0] = 1'b0;
    if (wrEn1) busyNext[WriteReg1] = 1'b0;
    if (issueEn) busyNext[IssueReg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy    <= '0;
      BusyCnt <= '0;
    end else begin
      if (wrEn0) regs[WriteReg0] <= WriteData0;
      if (wrEn1) regs[WriteReg1] <= WriteData1;
      busy    <= busyNext;
      BusyCnt <= popCount(busyNext);
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = (a == '0) ? '0 : regs[a];
`ifdef REGFILE_SB_BYPASS_EN
    if (!RST && wrEn1 && (WriteReg1 == a)) d = WriteData1;
    else if (!RST && wrEn0 && (WriteReg0 == a)) d = WriteData0;
`endif
    return d;
  endfunction

  function automatic logic busyPort(input logic [ADDR_W-1:0] a);
    logic b;
    b = (a == '0) ? 1'b0 : busy[a];
`ifdef REGFILE_SB_BYPASS_EN
    if (!RST && ((wrEn0 && (WriteReg0 == a)) || (wrEn1 && (WriteReg1 == a))))
      b = issueEn && (IssueReg == a);
`endif
    return b;
  endfunction

  always_comb begin
    ReadData1 = readPort(ReadReg1);
    ReadData2 = readPort(ReadReg2);
    ReadData3 = readPort(ReadReg3);
    Busy1     = busyPort(ReadReg1);
    Busy2     = busyPort(ReadReg2);
    Busy3     = busyPort(ReadReg3);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RegWre0 = 0, RegWre1 = 0, IssueWre = 0;
  logic [4:0]  WriteReg0 = 0, WriteReg1 = 0, IssueReg = 0;
  logic [31:0] WriteData0 = 0, WriteData1 = 0;
  logic [4:0]  ReadReg1 = 0, ReadReg2 = 0, ReadReg3 = 0;
  logic [31:0] ReadData1, ReadData2, ReadData3;
  logic        Busy1, Busy2, Busy3;
  logic [5:0]  BusyCnt;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .RegWre0(RegWre0), .RegWre1(RegWre1),
    .WriteReg0(WriteReg0), .WriteReg1(WriteReg1),
    .WriteData0(WriteData0), .WriteData1(WriteData1),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadReg3(ReadReg3),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ReadData3(ReadData3),
    .IssueWre(IssueWre), .IssueReg(IssueReg),
    .Busy1(Busy1), .Busy2(Busy2), .Busy3(Busy3),
    .BusyCnt(BusyCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd1, rd2, rd3;
    logic        b1, b2, b3;
    logic [5:0]  cnt;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    failures = 0;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", n, f, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle against the current inputs.
  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      exp_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      cmp(n, "ReadData1", ReadData1, e.rd1);
      cmp(n, "ReadData2", ReadData2, e.rd2);
      cmp(n, "ReadData3", ReadData3, e.rd3);
      cmp(n, "Busy1", {31'd0, Busy1}, {31'd0, e.b1});
      cmp(n, "Busy2", {31'd0, Busy2}, {31'd0, e.b2});
      cmp(n, "Busy3", {31'd0, Busy3}, {31'd0, e.b3});
      cmp(n, "BusyCnt", {26'd0, BusyCnt}, {26'd0, e.cnt});
    end
  end

  task automatic expectOut(input string n, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] rd3, input logic b1, input logic b2,
                           input logic b3, input logic [5:0] cnt);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.rd3 = rd3;
    e.b1 = b1; e.b2 = b2; e.b3 = b3; e.cnt = cnt;
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic iw, input logic [4:0] ia,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3);
    RegWre0 = we0; WriteReg0 = wa0; WriteData0 = wd0;
    RegWre1 = we1; WriteReg1 = wa1; WriteData1 = wd1;
    IssueWre = iw; IssueReg = ia;
    ReadReg1 = r1; ReadReg2 = r2; ReadReg3 = r3;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, r3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nextCycle();
    idle(5, 3, 9);
    expectOut("reset", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    RST = 1'b0;
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 0);
    expectOut("wr_r5_same", BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(5, 0, 0);
    expectOut("rd_r5", 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0, 0);
    expectOut("dual_r7_same", BYP ? 32'h22 : 32'h0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(7, 0, 0);
    expectOut("dual_r7", 32'h22, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 4);
    expectOut("issue_r3", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 3, 4);
    expectOut("issue_r4", 0, 0, 0, 0, 1, 0, 1);
    nextCycle();
    idle(0, 3, 4);
    expectOut("busy_r3_r4", 0, 0, 0, 0, 1, 1, 2);
    nextCycle();
    drive(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 3, 4);
    expectOut("wr_r3_same", 0, BYP ? 32'h33 : 32'h0, 0, 0, !BYP, 1, 2);
    nextCycle();
    idle(0, 3, 4);
    expectOut("wr_r3_clr", 0, 32'h33, 0, 0, 0, 1, 1);
    nextCycle();
    drive(1, 9, 32'h55, 0, 0, 0, 1, 9, 9, 3, 4);
    expectOut("iss_wr_r9_same", BYP ? 32'h55 : 32'h0, 32'h33, 0, BYP, 0, 1, 1);
    nextCycle();
    idle(9, 3, 4);
    expectOut("iss_wr_r9", 32'h55, 32'h33, 0, 1, 0, 1, 2);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
    expectOut("reissue_r9_same", 32'h55, 0, 0, 1, 0, 0, 2);
    nextCycle();
    idle(9, 0, 0);
    expectOut("reissue_r9", 32'h55, 0, 0, 1, 0, 0, 2);
    nextCycle();
    drive(1, 0, 32'hFFFF, 1, 0, 32'hFFFF, 1, 0, 0, 0, 0);
    expectOut("r0_same", 0, 0, 0, 0, 0, 0, 2);
    nextCycle();
    idle(0, 0, 0);
    expectOut("r0_after", 0, 0, 0, 0, 0, 0, 2);
    nextCycle();
    drive(1, 2, 32'hA5, 0, 0, 0, 0, 0, 0, 0, 2);
    expectOut("byp_r2_same", 0, 0, BYP ? 32'hA5 : 32'h0, 0, 0, 0, 2);
    nextCycle();
    drive(1, 6, 32'h1, 1, 6, 32'h2, 0, 0, 0, 6, 2);
    expectOut("byp_r6_prio", 0, BYP ? 32'h2 : 32'h0, 32'hA5, 0, 0, 0, 2);
    nextCycle();
    idle(0, 6, 2);
    expectOut("r6_r2_after", 0, 32'h2, 32'hA5, 0, 0, 0, 2);
    nextCycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0);
    expectOut("issue_r5", 32'hDEADBEEF, 0, 0, 0, 0, 0, 2);
    nextCycle();
    idle(5, 4, 9);
    expectOut("busy3", 32'hDEADBEEF, 0, 32'h55, 1, 1, 1, 3);
    nextCycle();
    RST = 1'b1;
    drive(1, 5, 32'h1, 1, 12, 32'h2, 1, 12, 5, 12, 9);
    expectOut("async_rst", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    expectOut("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    RST = 1'b0;
    idle(5, 12, 9);
    expectOut("rst_release", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    drive(1, 5, 32'h77, 0, 0, 0, 0, 0, 5, 0, 0);
    expectOut("post_rst_wr_same", BYP ? 32'h77 : 32'h0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(5, 0, 0);
    expectOut("post_rst_wr", 32'h77, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports RegWre0 / RegWre1  input  1  write enables for write ports 0 and 1.
REQ-006 The block SHALL have ports WriteReg0 / WriteReg1  input  ADDR_W  write addresses.
REQ-007 The block SHALL have ports WriteData0 / WriteData1  input  DATA_W  write data.
REQ-008 The block SHALL have ports ReadReg1 / ReadReg2 / ReadReg3  input  ADDR_W  read addresses.
REQ-009 The block SHALL have ports ReadData1 / ReadData2 / ReadData3  output  DATA_W  combinational read data.
REQ-010 The block SHALL have port IssueWre  input  1  marks IssueReg as having a pending writer.
REQ-011 The block SHALL have port IssueReg  input  ADDR_W  destination register being issued.
REQ-012 The block SHALL have ports Busy1 / Busy2 / Busy3  output  1  pending-write flag of ReadReg1..3.
REQ-013 The block SHALL have port BusyCnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-014 Register 0 SHALL read as zero, SHALL never be written, and SHALL never be busy; writes or issues to address 0 SHALL be ignored.
REQ-015 A write on port n SHALL occur at the rising CLK edge when RegWre<n>=1 and WriteReg<n>!=0.
REQ-016 When both ports write the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-017 Each register SHALL carry one busy bit; IssueWre=1 with IssueReg!=0 SHALL set the bit at the next edge.
REQ-018 A qualifying write on either port SHALL clear the busy bit of the written register at the next edge.
REQ-019 When an issue and a write target the same register in one cycle, the busy bit SHALL end set; the data SHALL still be written.
REQ-020 Issuing an already-busy register SHALL leave it busy; BusyCnt SHALL not double count.
REQ-021 BusyCnt SHALL be registered and SHALL equal the population count of busy bits after every edge; maximum value is 2**ADDR_W-1.
REQ-022 ReadDataN and BusyN SHALL be combinational functions of the current address and stored state, with zero-cycle latency.

Reset
REQ-023 Asserting RST SHALL immediately clear every register, every busy bit, and BusyCnt to 0, independent of CLK.
REQ-024 While RST=1, writes and issues SHALL be ignored; all ReadDataN, BusyN, and BusyCnt SHALL read 0.
REQ-025 Deasserting RST SHALL resume operation at the first subsequent rising edge, with no partial write from a cycle in which RST was high.

Configuration
REQ-026 When macro REGFILE_SB_BYPASS_EN is defined, a read of an address being written in the same cycle SHALL return the incoming WriteData, with port 1 priority; the matching BusyN SHALL read 0 unless the same cycle also issues that register.
REQ-027 When REGFILE_SB_BYPASS_EN is undefined, reads SHALL return stored contents only, so new data is visible the cycle after the write, and BusyN SHALL reflect stored busy bits only.

Verification
REQ-028 The bench SHALL cover: reset, then write 0xDEADBEEF to r5 via port 0; next cycle ReadReg1=5 -> ReadData1=0xDEADBEEF, Busy1=0.
REQ-029 The bench SHALL cover: same cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22 -> r7 reads 0x22.
REQ-030 The bench SHALL cover: issue r3, then r4 -> BusyCnt=2 and Busy2=1 for ReadReg2=3; writing r3 -> BusyCnt=1, Busy2=0.
REQ-031 The bench SHALL cover: same cycle, issue r9 and write r9=0x55 -> r9=0x55, Busy stays 1, BusyCnt increments by 1.
REQ-032 The bench SHALL cover: write r0=0xFFFF and issue r0 -> ReadData=0, Busy=0, BusyCnt unchanged.
REQ-033 The bench SHALL cover: with BYPASS_EN, write r2=0xA5 while ReadReg3=2 -> same-cycle ReadData3=0xA5; without BYPASS_EN -> old value, then 0xA5 next cycle.
REQ-034 The bench SHALL cover: assert RST mid-cycle with r5 busy -> outputs 0 at once, before any CLK edge.
